// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, command/response
// bytes and the frame builder (8 data bits plus odd parity).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESP_RESEND  = 8'hFE;

    function automatic logic [8:0] ps2_frame(input logic [7:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line with a falling-edge pulse.
// Resets to the idle-high level so reset never fakes an edge.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_line;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_fall = r_prev & ~r_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Define PS2TX_RETRY_EN to retry failed frames up to RETRY_MAX times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned REQ_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned RETRY_MAX      = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int unsigned M1 =
        (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned CNT_MAX =
        (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    ps2_state_t r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_idx, w_idx;
    logic [8:0]    r_frame, w_frame;
    logic          r_clk_oe, w_clk_oe;
    logic          r_data_oe, w_data_oe;
    logic          r_done, w_done;
    logic          w_fail;
    logic          w_timeout;
    logic          w_sclk, w_sdata, w_fall;

`ifdef PS2TX_RETRY_EN
    localparam int unsigned RW = $clog2(RETRY_MAX + 2);
    logic [RW-1:0] r_retry, w_retry;
`endif

    ps2_sync_edge u_clk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i_ps2_clk_in),
        .o_sync (w_sclk),
        .o_fall (w_fall)
    );

    ps2_sync_edge u_data_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i_ps2_data_in),
        .o_sync (w_sdata),
        .o_fall ()
    );

    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_frame   = r_frame;
        w_clk_oe  = r_clk_oe;
        w_data_oe = r_data_oe;
        w_done    = 1'b0;
        w_fail    = 1'b0;
`ifdef PS2TX_RETRY_EN
        w_retry   = r_retry;
`endif
        unique case (r_state)
            IDLE: begin
                if (i_tx_valid) begin
                    w_state   = INHIBIT;
                    w_frame   = ps2_frame(i_tx_data);
                    w_cnt     = '0;
                    w_clk_oe  = 1'b1;
                    w_data_oe = 1'b0;
`ifdef PS2TX_RETRY_EN
                    w_retry   = '0;
`endif
                end
            end
            INHIBIT: begin
                if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    w_state   = REQ;
                    w_cnt     = '0;
                    w_data_oe = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            REQ: begin
                if (r_cnt == CW'(REQ_CYCLES - 1)) begin
                    w_state  = SHIFT;
                    w_cnt    = '0;
                    w_idx    = '0;
                    w_clk_oe = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            SHIFT: begin
                w_cnt = r_cnt + 1'b1;
                if (w_timeout) begin
                    w_fail = 1'b1;
                end else if (w_fall) begin
                    if (r_idx == 4'd9) begin
                        w_data_oe = 1'b0;
                        w_state   = ACK;
                    end else begin
                        w_data_oe = ~r_frame[r_idx];
                        w_idx     = r_idx + 1'b1;
                    end
                end
            end
            ACK: begin
                w_cnt = r_cnt + 1'b1;
                if (w_timeout) begin
                    w_fail = 1'b1;
                end else if (w_fall) begin
                    if (!w_sdata) w_state = WAIT_IDLE;
                    else          w_fail  = 1'b1;
                end
            end
            WAIT_IDLE: begin
                w_cnt = r_cnt + 1'b1;
                if (w_timeout) begin
                    w_fail = 1'b1;
                end else if (w_sclk && w_sdata) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end
            end
            ERR: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        // Any failure lets go of both lines before deciding what comes next.
        if (w_fail) begin
            w_clk_oe  = 1'b0;
            w_data_oe = 1'b0;
            w_state   = ERR;
`ifdef PS2TX_RETRY_EN
            if (r_retry < RW'(RETRY_MAX)) begin
                w_state  = INHIBIT;
                w_cnt    = '0;
                w_clk_oe = 1'b1;
                w_retry  = r_retry + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_frame   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
`ifdef PS2TX_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_frame   <= w_frame;
            r_clk_oe  <= w_clk_oe;
            r_data_oe <= w_data_oe;
            r_done    <= w_done;
`ifdef PS2TX_RETRY_EN
            r_retry   <= w_retry;
`endif
        end
    end

    assign o_tx_ready    = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_err         = (r_state == ERR);
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with pull-up bus and a device model
// clocking at 1/40 of clk.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err;
    logic       clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    int total = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int oe_bad = 0;
    int inh_cnt = 0;
    logic prev_err = 1'b0;
    logic prev_clk_oe = 1'b0;

    assign clk_line  = !(clk_oe || dev_clk_low);
    assign data_line = !(data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .REQ_CYCLES     (4),
        .TIMEOUT_CYCLES (5000),
        .RETRY_MAX      (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .i_ps2_clk_in  (clk_line),
        .i_ps2_data_in (data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (prev_err && (clk_oe || data_oe)) oe_bad++;
        if (clk_oe && !prev_clk_oe) inh_cnt++;
        prev_err = err;
        prev_clk_oe = clk_oe;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] b);
        @(negedge clk);
        check("accept_ready", 32'(tx_ready), 32'd1);
        tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data = ~b;
        check("clk_oe_latency", 32'(clk_oe), 32'd1);
    endtask

    task automatic phases();
        int n;
        @(negedge clk);
        n = 0;
        while (clk_oe && !data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), 32'd20);
        n = 0;
        while (clk_oe && data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("req_len", 32'(n), 32'd4);
    endtask

    task automatic dev_frame(input logic ack_ok,
                             input int abort_fall,
                             output logic [10:0] cap);
        cap = '0;
        repeat (20) @(negedge clk);
        cap[0] = data_line;
        for (int i = 0; i < 10; i++) begin
            if (i + 1 == abort_fall) begin
                dev_clk_low = 1'b1;
                return;
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clk);
            cap[i+1] = data_line;
        end
        if (ack_ok) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_ok(input logic [7:0] b, input logic [10:0] exp);
        logic [10:0] cap;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        accept(b);
        phases();
        dev_frame(1'b1, 0, cap);
        repeat (100) @(negedge clk);
        check("frame_bits", 32'(cap), 32'(exp));
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("no_err", 32'(err_cnt - e0), 32'd0);
        check("ready_back", 32'(tx_ready), 32'd1);
    endtask

    initial begin
        logic [10:0] cap;
        int d0, e0, i0, n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_oe", 32'(clk_oe), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_ok(8'hED, 11'b1_1_11101101_0);
        run_ok(8'h07, 11'b1_0_00000111_0);
        run_ok(8'h00, 11'b1_1_00000000_0);

        d0 = done_cnt;
        e0 = err_cnt;
        accept(8'h07);
        phases();
        dev_frame(1'b0, 0, cap);
        repeat (100) @(negedge clk);
        check("nack_err", 32'(err_cnt - e0), 32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_released", 32'(oe_bad), 32'd0);

        e0 = err_cnt;
        accept(8'hED);
        phases();
        n = 0;
        while (!err && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_len", 32'(n), 32'd5000);
        check("timeout_oe", 32'({clk_oe, data_oe}), 32'd0);
        @(negedge clk);
        check("timeout_pulse", 32'(err), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);

        e0 = err_cnt;
        accept(8'hED);
        phases();
        dev_frame(1'b1, 5, cap);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_oe", 32'({clk_oe, data_oe}), 32'd0);
        check("rst_mid_idle", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_mid_no_err", 32'(err_cnt - e0), 32'd0);

        run_ok(8'hFF, 11'b1_1_11111111_0);

`ifdef PS2TX_RETRY_EN
        d0 = done_cnt;
        e0 = err_cnt;
        i0 = inh_cnt;
        accept(8'hED);
        for (int a = 0; a < 3; a++) begin
            n = 0;
            while (!(!clk_oe && data_oe) && n < 200) begin
                @(negedge clk);
                n++;
            end
            dev_frame(a == 2, 0, cap);
        end
        repeat (100) @(negedge clk);
        check("retry_inhibits", 32'(inh_cnt - i0), 32'd3);
        check("retry_no_err", 32'(err_cnt - e0), 32'd0);
        check("retry_done", 32'(done_cnt - d0), 32'd1);
`else
        i0 = inh_cnt;
        check("inhibit_total", 32'(i0), 32'd7);
`endif

        check("done_err_exclusive", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
